rx_mod: RTL and testbench
=========================

RX_MOD -- requirements
Module: rx_mod

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 16, clk cycles per UART bit period; even, minimum 4.
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: rxd  input  1  asynchronous serial line; idle high.
REQ-005 SHALL have port: rx_ack  input  1  consumer has taken dout; sampled on clk.
REQ-006 SHALL have port: dout  output  8  last correctly received byte.
REQ-007 SHALL have port: rx_valid  output  1  dout holds an unconsumed byte.
REQ-008 SHALL have port: frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port: overrun  output  1  sticky: a byte was lost because rx_valid was still set.

Function
REQ-010 SHALL pass rxd through a 2-flop synchronizer (rxd_s); all decisions use rxd_s only.
REQ-011 SHALL frame as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, with a bit-period counter (0..CLKS_PER_BIT-1) and a 3-bit data-bit counter.
REQ-013 SHALL keep an "armed" flag: set when rxd_s==1 is seen in IDLE; IDLE -> START only when armed and rxd_s==0; entering START clears the counter and the armed flag.
REQ-014 SHALL, in START, sample rxd_s when the counter reaches CLKS_PER_BIT/2-1: 0 -> DATA with counter cleared; 1 -> IDLE (glitch, no flag, no output change).
REQ-015 SHALL, in DATA, sample rxd_s when the counter reaches CLKS_PER_BIT-1, shift the bit into bit 7 of the shift register (right shift), clear the counter, and go to STOP after the 8th bit.
REQ-016 SHALL, in STOP, sample rxd_s when the counter reaches CLKS_PER_BIT-1, then return to IDLE.
REQ-017 SHALL, on a stop sample of 1, load dout from the shift register and set rx_valid on the next clk edge.
REQ-018 SHALL, on a stop sample of 0, pulse frame_err high for exactly one cycle and leave dout and rx_valid unchanged.
REQ-019 SHALL clear rx_valid on the cycle after rx_ack==1; rx_ack while rx_valid==0 has no effect.
REQ-020 SHALL, when a good byte completes while rx_valid==1 and rx_ack==0, overwrite dout, keep rx_valid=1, and set overrun.
REQ-021 SHALL, when a good byte completes in the same cycle as rx_ack==1, load the new byte, keep rx_valid=1, and leave overrun unchanged.
REQ-022 SHALL clear overrun only on rx_ack==1, unless REQ-020 sets it in the same cycle, in which case set wins.
REQ-023 SHALL place the stop sample exactly CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the first cycle in START, with rx_valid/frame_err visible one cycle later.
REQ-024 SHALL leave a line held low after a frame error (break) producing no further frames until rxd_s returns high.

Reset
REQ-025 SHALL, on rst=1 at any time including mid-frame: state IDLE, armed=0, counters 0, shift register 0, dout=8'h00, rx_valid=0, frame_err=0, overrun=0; synchronizer flops set to 1.
REQ-026 SHALL, after rst deasserts, start no frame until rxd_s has been seen high at least once.

Verification
REQ-027 SHALL cover: CLKS_PER_BIT=16, frame 0xA5 -> dout=8'hA5, rx_valid=1 at the REQ-023 cycle, frame_err=0, overrun=0; rx_ack -> rx_valid=0 next cycle.
REQ-028 SHALL cover: rxd low pulse of 4 clk cycles from idle -> return to IDLE, no rx_valid, no frame_err.
REQ-029 SHALL cover: frame 0x3C with stop bit forced 0 -> one-cycle frame_err, dout and rx_valid unchanged; line held low -> no new frame until rxd is high.
REQ-030 SHALL cover: 0x11 then 0x22 back-to-back without rx_ack -> dout=8'h22, rx_valid=1, overrun=1; rx_ack -> rx_valid=0, overrun=0.
REQ-031 SHALL cover: rx_ack coincident with completion of a second byte 0x7E -> dout=8'h7E, rx_valid=1, overrun=0.
REQ-032 SHALL cover: rst pulsed during data bit 4 of a frame -> all outputs at reset values; the next complete frame 0x81 is received correctly.

Source files
------------

// File: rtl/rx_mod.sv
// rx_mod -- UART receiver, 8N1, oversampled by CLKS_PER_BIT clocks per bit.
//
// Ports:
//   clk       in   system clock, all state changes on the rising edge
//   rst       in   asynchronous active-high reset
//   rxd       in   asynchronous serial line, idle high
//   rx_ack    in   consumer has taken dout
//   dout      out  [7:0] last correctly received byte
//   rx_valid  out  dout holds an unconsumed byte
//   frame_err out  one-cycle pulse, stop bit sampled low
//   overrun   out  sticky, a byte was overwritten before it was acknowledged
module rx_mod #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] dout,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    sync_q;
    logic          rxd_s;
    logic [1:0]    state_q, state_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          good, bad;

    assign rxd_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        good    = 1'b0;
        bad     = 1'b0;
        case (state_q)
            IDLE: begin
                // Only a high-to-low transition starts a frame; a line that
                // stays low (break, or low out of reset) never re-triggers.
                if (rxd_s)
                    armed_d = 1'b1;
                if (armed_q && !rxd_s) begin
                    state_d = START;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    // High at mid start bit is a glitch: drop it silently.
                    state_d = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    good    = rxd_s;
                    bad     = !rxd_s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output side. A completing byte takes priority over an ack; overrun is
    // left alone when the ack and the new byte coincide since nothing is lost.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        ferr_d  = bad;
        if (good) begin
            dout_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rx_ack)
                ovr_d = 1'b1;
        end else if (rx_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            dout_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rxd};
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout      = dout_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_rx_mod.sv
// tb_rx_mod -- directed bench for rx_mod: table of good frames plus
// hand-written sequences for glitch, framing error / break, coincident ack
// and reset in mid-frame.
module tb_rx_mod;

    localparam int N   = 16;
    // 2 synchronizer edges + 1 edge into START + N/2 + 9*N to the stop sample
    localparam int LAT = 3 + N / 2 + 9 * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] dout;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;
    int upd_cyc   = -1;
    int ferr_cnt  = 0;
    int fbase;
    logic       v_prev = 1'b0;
    logic [7:0] d_prev = 8'h00;

    rx_mod #(.CLKS_PER_BIT(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_ack    (rx_ack),
        .dout      (dout),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the edge at which a new byte becomes visible, and count
    // frame_err high cycles.
    always @(negedge clk) begin
        if ((rx_valid && !v_prev) || (dout != d_prev))
            upd_cyc = cyc;
        v_prev = rx_valid;
        d_prev = dout;
        if (frame_err)
            ferr_cnt = ferr_cnt + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic [7:0] e_dout;
        logic       e_valid;
        logic       e_ovr;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        @(posedge clk);
        #1;
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (N) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_ack();
        @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
    endtask

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
        tbl[1] = '{8'h11, 1'b0, 8'h11, 1'b1, 1'b0};
        tbl[2] = '{8'h22, 1'b1, 8'h22, 1'b1, 1'b1};
        tbl[3] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[4] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_valid", 32'(rx_valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // good frames
        for (int i = 0; i < 5; i++) begin
            fbase = ferr_cnt;
            send_frame(tbl[i].data, 1'b1);
            chk($sformatf("v%0d_dout", i), 32'(dout), 32'(tbl[i].e_dout));
            chk($sformatf("v%0d_valid", i), 32'(rx_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_ovr", i), 32'(overrun), 32'(tbl[i].e_ovr));
            chk($sformatf("v%0d_ferr", i), 32'(ferr_cnt - fbase), 32'd0);
            chk($sformatf("v%0d_lat", i), 32'(upd_cyc - start_cyc), 32'(LAT));
            if (tbl[i].ack) begin
                do_ack();
                chk($sformatf("v%0d_ack_valid", i), 32'(rx_valid), 32'h0);
                chk($sformatf("v%0d_ack_ovr", i), 32'(overrun), 32'h0);
            end
        end

        // 4-cycle low glitch from idle
        fbase = ferr_cnt;
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (3 * N) @(posedge clk);
        #1;
        chk("glitch_valid", 32'(rx_valid), 32'h0);
        chk("glitch_dout", 32'(dout), 32'hFF);
        chk("glitch_ferr", 32'(ferr_cnt - fbase), 32'd0);

        // framing error followed by a held-low line
        send_frame(8'h5A, 1'b1);
        chk("pre_ferr_dout", 32'(dout), 32'h5A);
        fbase = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (3 * N) @(posedge clk);
        #1;
        chk("ferr_pulses", 32'(ferr_cnt - fbase), 32'd1);
        chk("ferr_dout", 32'(dout), 32'h5A);
        chk("ferr_valid", 32'(rx_valid), 32'h1);
        chk("ferr_ovr", 32'(overrun), 32'h0);
        rxd = 1'b1;
        repeat (2 * N) @(posedge clk);
        #1;
        chk("break_ferr", 32'(ferr_cnt - fbase), 32'd1);
        send_frame(8'h96, 1'b1);
        chk("post_brk_dout", 32'(dout), 32'h96);
        chk("post_brk_ovr", 32'(overrun), 32'h1);
        do_ack();
        chk("post_brk_ack", 32'({rx_valid, overrun}), 32'h0);

        // ack coincident with completion of a second byte
        send_frame(8'h55, 1'b1);
        chk("co_first", 32'({rx_valid, dout}), 32'h155);
        fork
            send_frame(8'h7E, 1'b1);
            begin
                repeat (LAT) @(posedge clk);
                #1 rx_ack = 1'b1;
                @(posedge clk);
                #1 rx_ack = 1'b0;
            end
        join
        chk("co_dout", 32'(dout), 32'h7E);
        chk("co_valid", 32'(rx_valid), 32'h1);
        chk("co_ovr", 32'(overrun), 32'h0);
        do_ack();
        chk("co_ack_valid", 32'(rx_valid), 32'h0);

        // reset during data bit 4, with outputs non-reset beforehand
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        chk("pre_rst_ovr", 32'(overrun), 32'h1);
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (N) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 rxd = (8'h5A >> i) & 8'h01;
            repeat (N) @(posedge clk);
        end
        #1 rxd = 1'b1;
        repeat (N / 2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_dout", 32'(dout), 32'h00);
        chk("mid_rst_flags", 32'({rx_valid, frame_err, overrun}), 32'h0);
        rst = 1'b0;
        fbase = ferr_cnt;
        repeat (2 * N) @(posedge clk);
        #1;
        chk("after_rst_flags", 32'({rx_valid, overrun}), 32'h0);
        send_frame(8'h81, 1'b1);
        chk("rx81_dout", 32'(dout), 32'h81);
        chk("rx81_valid", 32'(rx_valid), 32'h1);
        chk("rx81_ovr", 32'(overrun), 32'h0);
        chk("rx81_ferr", 32'(ferr_cnt - fbase), 32'd0);
        chk("rx81_lat", 32'(upd_cyc - start_cyc), 32'(LAT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
